// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the radix-2 DIT FFT butterfly scheduler.
package fft_sched_pkg;

  // Scheduler FSM states, one butterfly takes RD_V..WR_V (five cycles).
  typedef enum logic [2:0] {
    IDLE,
    RD_V,
    RD_U,
    CALC,
    WR_U,
    WR_V,
    PAUSE,
    DONE
  } sched_state_e;

  // Write-data select codes for the sample RAM write port.
  localparam logic WSEL_U = 1'b0;
  localparam logic WSEL_V = 1'b1;

endpackage

// File: rtl/fft_idx_counter.sv
// Nested stage/group/butterfly counters and the derived u/v/w indices
// for an in-place radix-2 DIT FFT.
module fft_idx_counter #(
  parameter  int FFT_SIZE = 1024,
  localparam int LOG2_N   = $clog2(FFT_SIZE),
  localparam int STG_W    = $clog2(LOG2_N + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              advance,
  input  logic              clear,
  output logic [LOG2_N-1:0] u,
  output logic [LOG2_N-1:0] v,
  output logic [LOG2_N-1:0] w,
  output logic [STG_W-1:0]  s,
  output logic              last_bfly,
  output logic              last_stage
);
  import fft_sched_pkg::*;

  localparam logic [LOG2_N-1:0] ONE    = LOG2_N'(1);
  localparam logic [LOG2_N-1:0] HALF   = LOG2_N'(FFT_SIZE / 2);
  localparam logic [STG_W-1:0]  S_LAST = STG_W'(LOG2_N - 1);

  logic [STG_W-1:0]  s_q;
  logic [LOG2_N-1:0] g_q;
  logic [LOG2_N-1:0] b_q;
  logic [LOG2_N-1:0] b_max;
  logic [LOG2_N-1:0] g_max;
  logic              b_wrap;
  logic              g_wrap;

  // Wrap limits and index arithmetic; all results truncate to the RAM address width.
  always_comb begin
    b_max      = (ONE << s_q) - ONE;
    g_max      = (HALF >> s_q) - ONE;
    b_wrap     = (b_q == b_max);
    g_wrap     = (g_q == g_max);
    last_stage = (s_q == S_LAST);
    last_bfly  = b_wrap && g_wrap;
    u          = (g_q << (s_q + STG_W'(1))) + b_q;
    v          = u + (ONE << s_q);
    w          = b_q << (S_LAST - s_q);
    s          = s_q;
  end

  // Butterfly counter is innermost, then group, then stage; the last stage wraps back to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (clear) begin
      s_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (advance) begin
      if (b_wrap) begin
        b_q <= '0;
        if (g_wrap) begin
          g_q <= '0;
          s_q <= last_stage ? '0 : s_q + STG_W'(1);
        end else begin
          g_q <= g_q + ONE;
        end
      end else begin
        b_q <= b_q + ONE;
      end
    end
  end

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Sequencer for the in-place radix-2 DIT FFT: FSM plus RAM/ROM/strobe decode.
module fft_butterfly_scheduler #(
  parameter  int FFT_SIZE = 1024,
  localparam int LOG2_N   = $clog2(FFT_SIZE),
  localparam int STG_W    = $clog2(LOG2_N + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LOG2_N-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic              mem_wsel_o,
  output logic [LOG2_N-1:0] tw_addr_o,
  output logic              cap_v_o,
  output logic              cap_u_o,
  output logic [STG_W-1:0]  stage_o
);
  import fft_sched_pkg::*;

  sched_state_e      state;
  logic [LOG2_N-1:0] u_idx;
  logic [LOG2_N-1:0] v_idx;
  logic [LOG2_N-1:0] w_idx;
  logic [STG_W-1:0]  s_idx;
  logic              last_bfly;
  logic              last_stage;
  logic              advance;
  logic              clear;

  assign advance = (state == WR_V);
  assign clear   = (state == DONE);

  fft_idx_counter #(
    .FFT_SIZE(FFT_SIZE)
  ) u_idx_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance   (advance),
    .clear     (clear),
    .u         (u_idx),
    .v         (v_idx),
    .w         (w_idx),
    .s         (s_idx),
    .last_bfly (last_bfly),
    .last_stage(last_stage)
  );

  // Walk one butterfly per RD_V..WR_V pass; stalls are only taken after a full write-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state <= RD_V;
        RD_V:    state <= RD_U;
        RD_U:    state <= CALC;
        CALC:    state <= WR_U;
        WR_U:    state <= WR_V;
        WR_V: begin
          if (last_bfly && last_stage) state <= DONE;
          else if (stall_i)            state <= PAUSE;
          else                         state <= RD_V;
        end
        PAUSE:   if (!stall_i) state <= RD_V;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and addresses decode straight from the state register and the live counters.
  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    mem_wsel_o = WSEL_U;
    cap_v_o    = 1'b0;
    cap_u_o    = 1'b0;
    tw_addr_o  = (state == IDLE) ? '0 : w_idx;
    busy_o     = (state != IDLE) && (state != DONE);
    done_o     = (state == DONE);
    stage_o    = s_idx;
    case (state)
      RD_V:  mem_addr_o = v_idx;
      RD_U: begin
        mem_addr_o = u_idx;
        cap_v_o    = 1'b1;
      end
      CALC: begin
        mem_addr_o = u_idx;
        cap_u_o    = 1'b1;
      end
      WR_U: begin
        mem_addr_o = u_idx;
        mem_we_o   = 1'b1;
        mem_wsel_o = WSEL_U;
      end
      WR_V: begin
        mem_addr_o = v_idx;
        mem_we_o   = 1'b1;
        mem_wsel_o = WSEL_V;
      end
      PAUSE: mem_addr_o = v_idx;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Directed self-checking bench for fft_butterfly_scheduler at N=8 and N=2.
module tb_fft_butterfly_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic start8, stall8, start2, stall2;

  logic       busy8, done8, we8, wsel8, capv8, capu8;
  logic [2:0] addr8, tw8;
  logic [1:0] stage8;

  logic       busy2, done2, we2, wsel2, capv2, capu2;
  logic [0:0] addr2, tw2;
  logic [0:0] stage2;

  int vectorCount = 0;
  int miscompareCount = 0;

  // Hand-derived (u,v,w) for the twelve butterflies of an 8-point transform.
  int tabU[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tabV[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tabW[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // N=2 expected output words per cycle: {busy,done,we,wsel,capv,capu,addr,tw,stage}.
  logic [31:0] exp2[7] = '{32'h104, 32'h110, 32'h108, 32'h140, 32'h164, 32'h080, 32'h000};

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  fft_butterfly_scheduler #(.FFT_SIZE(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .stall_i(stall8),
    .busy_o(busy8), .done_o(done8), .mem_addr_o(addr8), .mem_we_o(we8),
    .mem_wsel_o(wsel8), .tw_addr_o(tw8), .cap_v_o(capv8), .cap_u_o(capu8),
    .stage_o(stage8)
  );

  fft_butterfly_scheduler #(.FFT_SIZE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .stall_i(stall2),
    .busy_o(busy2), .done_o(done2), .mem_addr_o(addr2), .mem_we_o(we2),
    .mem_wsel_o(wsel2), .tw_addr_o(tw2), .cap_v_o(capv2), .cap_u_o(capu2),
    .stage_o(stage2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vectorCount++;
    if (got !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    end
  endtask

  function automatic logic [31:0] obs8();
    return {18'd0, busy8, done8, we8, wsel8, capv8, capu8, addr8, tw8, stage8};
  endfunction

  function automatic logic [31:0] obs2();
    return {23'd0, busy2, done2, we2, wsel2, capv2, capu2, addr2, tw2, stage2};
  endfunction

  function automatic logic [31:0] mk8(input bit busy, input bit done, input bit we, input bit wsel,
                                      input bit capv, input bit capu, input int addr, input int tw,
                                      input int stage);
    return {18'd0, busy, done, we, wsel, capv, capu, 3'(addr), 3'(tw), 2'(stage)};
  endfunction

  // Expected N=8 outputs in butterfly cycle e (1..60) of an unstalled run.
  function automatic logic [31:0] expBfly(input int e);
    int bi = (e - 1) / 5;
    int ph = (e - 1) % 5;
    int s  = bi / 4;
    logic [31:0] r;
    case (ph)
      0:       r = mk8(1, 0, 0, 0, 0, 0, tabV[bi], tabW[bi], s);
      1:       r = mk8(1, 0, 0, 0, 1, 0, tabU[bi], tabW[bi], s);
      2:       r = mk8(1, 0, 0, 0, 0, 1, tabU[bi], tabW[bi], s);
      3:       r = mk8(1, 0, 1, 0, 0, 0, tabU[bi], tabW[bi], s);
      default: r = mk8(1, 0, 1, 1, 0, 0, tabV[bi], tabW[bi], s);
    endcase
    return r;
  endfunction

  // One N=8 run from a start pulse (or held start), with an optional stall window.
  task automatic applyStimulus(input int stallFrom, input int stallTo, input int pauseAt,
                               input int pauseLen, input bit holdStart);
    int weCount = 0;
    int e;
    int endCycle = 62 + pauseLen + (holdStart ? 1 : 0);
    start8 = 1'b1;
    for (int j = 1; j <= endCycle; j++) begin
      @(posedge clk);
      #1;
      start8 = holdStart;
      stall8 = (j >= stallFrom) && (j <= stallTo);
      if (j <= pauseAt) e = j;
      else if (j <= pauseAt + pauseLen) e = 0;
      else e = j - pauseLen;
      if (e == 0)
        checkOutput($sformatf("pause c%0d", j), obs8() & 32'h3F00, mk8(1, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (e <= 60)
        checkOutput($sformatf("bfly c%0d", j), obs8(), expBfly(e));
      else if (e == 61)
        checkOutput($sformatf("done c%0d", j), obs8(), mk8(0, 1, 0, 0, 0, 0, 0, 0, 0));
      else if (e == 62)
        checkOutput($sformatf("idle c%0d", j), obs8(), 32'd0);
      else
        checkOutput($sformatf("rerun c%0d", j), obs8(), expBfly(1));
      if (we8) weCount++;
    end
    start8 = 1'b0;
    stall8 = 1'b0;
    checkOutput("write count", weCount, 24);
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0;
    stall8 = 1'b0;
    start2 = 1'b0;
    stall2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset dut8", obs8(), 32'd0);
    checkOutput("reset dut2", obs2(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle no start", obs8(), 32'd0);

    $display("[TB] plain run, N=8");
    applyStimulus(0, -1, 0, 0, 1'b0);

    $display("[TB] stalled run, N=8");
    applyStimulus(7, 16, 10, 7, 1'b0);

    $display("[TB] start held high, N=8");
    applyStimulus(0, -1, 0, 0, 1'b1);

    $display("[TB] reset during stage 1 CALC");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("reset clean", obs8(), 32'd0);
    start8 = 1'b1;
    for (int j = 1; j <= 23; j++) begin
      @(posedge clk);
      #1;
      start8 = 1'b0;
    end
    checkOutput("pre-reset CALC", obs8(), expBfly(23));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", obs8(), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held in reset", obs8(), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post-reset idle %0d", j), obs8(), 32'd0);
    end
    applyStimulus(0, -1, 0, 0, 1'b0);

    $display("[TB] single butterfly, N=2");
    start2 = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk);
      #1;
      start2 = 1'b0;
      checkOutput($sformatf("n2 c%0d", j), obs2(), exp2[j-1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
